// File: rtl/vga_cell_fetch.sv
// Game-of-Life VGA back end: row prefetch from dmem during h-blank, 2-stage cell-to-RGB pipeline.
// Optional grid overlay enabled by defining GOL_GRID_EN.
module vga_cell_fetch #(
  parameter int VGA_BITS   = 8,
  parameter int CELL_SHIFT = 5,
  parameter int COLS       = 20,
  parameter int ROWS       = 15,
  parameter int H_ACTIVE   = 640,
  parameter int V_TOTAL    = 525,
  parameter int BASE_WORD  = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          h_cnt,
  input  logic [9:0]          v_cnt,
  input  logic                in_de,
  input  logic                in_hs,
  input  logic                in_vs,
  output logic [8:0]          mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic [VGA_BITS-1:0] vga_r,
  output logic [VGA_BITS-1:0] vga_g,
  output logic [VGA_BITS-1:0] vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic                busy
);
  localparam int WPR = COLS / 4;
  localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int CW  = 10 - CELL_SHIFT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [8:0]             addr_q, addr_d;
  logic                   cap_vld_q;
  logic [KW-1:0]          cap_idx_q;
  logic [WPR-1:0][31:0]   rowbuf_q;
  logic [9:0]             vnext, nr;
  logic                   trig;

  // Next line's cell row; the last line of the frame prefetches row 0.
  always_comb begin
    vnext = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    nr    = vnext >> CELL_SHIFT;
    trig  = (h_cnt == 10'(H_ACTIVE)) && (nr < 10'(ROWS));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (trig) begin
        state_d = ISSUE;
        k_d     = '0;
        addr_d  = 9'(BASE_WORD) + nr[8:0] * 9'(WPR);
      end
      ISSUE: begin
        if (k_q == KW'(WPR - 1)) state_d = DRAIN;
        else begin
          k_d    = k_q + KW'(1);
          addr_d = addr_q + 9'd1;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      rowbuf_q  <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      // Read data trails the address by one cycle, so the slot index does too.
      cap_vld_q <= (state_q == ISSUE);
      cap_idx_q <= k_q;
      for (int w = 0; w < WPR; w++)
        if (cap_vld_q && cap_idx_q == KW'(w)) rowbuf_q[w] <= mem_rdata;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);

  // Pixel pipeline stage 1
  logic [CW-1:0] cell1_q;
  logic          de1_q, hs1_q, vs1_q;
`ifdef GOL_GRID_EN
  logic          grid1_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell1_q <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
`ifdef GOL_GRID_EN
      grid1_q <= 1'b0;
`endif
    end else begin
      cell1_q <= h_cnt[9:CELL_SHIFT];
      de1_q   <= in_de;
      hs1_q   <= in_hs;
      vs1_q   <= in_vs;
`ifdef GOL_GRID_EN
      grid1_q <= (h_cnt[CELL_SHIFT-1:0] == '0) || (v_cnt[CELL_SHIFT-1:0] == '0);
`endif
    end
  end

  // One-hot cell match; indices >= COLS match nothing and read as dead.
  logic [COLS-1:0] hit;
  for (genvar c = 0; c < COLS; c++) begin : g_cell
    assign hit[c] = (cell1_q == CW'(c)) && (|rowbuf_q[c/4][(c%4)*8 +: 8]);
  end

  logic [VGA_BITS-1:0] r_d, g_d, b_d;
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de1_q) begin
      if (|hit) begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
`ifdef GOL_GRID_EN
      if (grid1_q) begin
        r_d = '0;
        g_d = VGA_BITS'(1) << (VGA_BITS - 1);
        b_d = '0;
      end
`endif
    end
  end

  // Pixel pipeline stage 2
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      vga_de <= 1'b0;
    end else begin
      vga_r  <= r_d;
      vga_g  <= g_d;
      vga_b  <= b_d;
      vga_hs <= hs1_q;
      vga_vs <= vs1_q;
      vga_de <= de1_q;
    end
  end
endmodule

// File: tb/tb_vga_cell_fetch.sv
// Directed bench for vga_cell_fetch: dmem model, pixel scoreboard queue, fetch address/busy checks.
module tb_vga_cell_fetch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  h_cnt, v_cnt;
  logic        in_de, in_hs, in_vs;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, busy;

  vga_cell_fetch dut (
    .clk(clk), .reset_n(reset_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .busy(busy)
  );

  always #20 clk = ~clk;

  logic [31:0] mem [0:511];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model_buf [0:19];
  logic [8:0]  last_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input int h, input int v, input bit de, hs, vs);
    logic [7:0] r, g, b;
    int c;
    r = 0; g = 0; b = 0;
    c = h >> 5;
    if (de) begin
      if (c < 20 && model_buf[c] != 8'h00) begin
        r = 8'hFF; g = 8'hFF; b = 8'hFF;
      end
`ifdef GOL_GRID_EN
      if (h % 32 == 0 || v % 32 == 0) begin
        r = 8'h00; g = 8'h80; b = 8'h00;
      end
`endif
    end
    return {5'b0, r, g, b, hs, vs, de};
  endfunction

  function automatic logic [31:0] obs_pix();
    return {5'b0, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de};
  endfunction

  task automatic step(input int h, input int v, input bit de, hs, vs);
    h_cnt = h[9:0]; v_cnt = v[9:0]; in_de = de; in_hs = hs; in_vs = vs;
    exp_q.push_back(exp_pix(h, v, de, hs, vs));
    @(posedge clk); #1;
    if (exp_q.size() >= 2) chk("pix", obs_pix(), exp_q.pop_front());
  endtask

  task automatic blank(input int v, input int n);
    int vn, nr;
    bit fire;
    logic [8:0] base;
    logic [31:0] w;
    vn   = (v == 524) ? 0 : v + 1;
    nr   = vn >> 5;
    fire = (nr < 15);
    base = 9'(nr * 5);
    for (int i = 0; i < n; i++) begin
      step(640 + i, v, 1'b0, (i >= 8), 1'b0);
      if (fire) begin
        chk("busy", {31'b0, busy}, {31'b0, (i <= 5)});
        chk("addr", {23'b0, mem_addr}, {23'b0, (i <= 4) ? base + 9'(i) : base + 9'd4});
      end else begin
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("addr_hold", {23'b0, mem_addr}, {23'b0, last_addr});
      end
    end
    if (fire && n >= 7) begin
      last_addr = base + 9'd4;
      for (int c = 0; c < 20; c++) begin
        w = mem[base + 9'(c / 4)];
        model_buf[c] = w[(c % 4) * 8 +: 8];
      end
    end
  endtask

  task automatic line(input int v);
    for (int h = 0; h < 640; h++) step(h, v, 1'b1, 1'b0, 1'b0);
    blank(v, 16);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int c = 0; c < 20; c++) model_buf[c] = '0;
    mem[5]  = 32'h0000_0100;   // row 1, cell 1
    mem[14] = 32'hFF00_0000;   // row 2, cell 19
    reset_n = 1'b0;
    h_cnt = '0; v_cnt = '0; in_de = 0; in_hs = 0; in_vs = 0;
    #5;
    chk("rst_pix", obs_pix(), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr", {23'b0, mem_addr}, 32'd0);
    #10 reset_n = 1'b1;

    line(31);            // dead line, fetch row 1 -> addr 5..9
    line(32);            // cell 1 alive
    line(63);            // fetch row 2 -> addr 10..14
    line(64);            // cell 19 alive, x=640 de=0 gives 0
    blank(479, 16);      // nr = 15: no fetch
    blank(524, 16);      // frame wrap: row 0 -> addr 0..4
    blank(39, 16);       // row 1 again
    line(40);            // (32,40) vs (33,40)

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 639), 40, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(0, 40, 1'b0, 1'b0, 1'b0);
    step(0, 40, 1'b0, 1'b0, 1'b0);

    // Reset while in ISSUE
    blank(31, 2);
    #5 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_pix", obs_pix(), 32'd0);
    chk("midrst_addr", {23'b0, mem_addr}, 32'd0);
    exp_q.delete();
    for (int c = 0; c < 20; c++) model_buf[c] = '0;
    last_addr = '0;
    #6 reset_n = 1'b1;
    line(41);            // buffer cleared; refetch row 1 cleanly
    line(42);
    step(0, 42, 1'b0, 1'b0, 1'b0);
    step(0, 42, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
